speicher_arbiter: RTL
=====================

# speicher_arbiter

Arbitrates the processor's single memory port between instruction fetch and data load/store. Sits between the control unit (`Steuerung`) and the memory, and returns the completion pulses `BefehlGeladen`, `DatenGeladen` and `DatenGespeichert` that advance the control unit's phases. Memory latency is variable: the arbiter holds each access until `SpeicherBereit` is seen. A watchdog aborts accesses that never complete.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data word width
- TIMEOUT, 255, maximum access cycles before abort; 0 disables the watchdog
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- LoadBefehlSignal  in  1  fetch request (level)
- BefehlAdresse  in  ADDR_WIDTH  fetch address
- Befehl  out  DATA_WIDTH  fetched instruction word, held
- BefehlGeladen  out  1  one-cycle fetch-complete pulse
- LoadDatenSignal  in  1  data read request (level)
- StoreDatenSignal  in  1  data write request (level)
- DatenAdresse  in  ADDR_WIDTH  data address
- SchreibDaten  in  DATA_WIDTH  store data
- LeseDaten  out  DATA_WIDTH  loaded data word, held
- DatenGeladen  out  1  one-cycle load-complete pulse
- DatenGespeichert  out  1  one-cycle store-complete pulse
- SpeicherAdresse  out  ADDR_WIDTH  memory address
- SpeicherDaten  out  DATA_WIDTH  memory write data
- SpeicherLesen  out  1  memory read strobe
- SpeicherSchreiben  out  1  memory write strobe
- SpeicherBereit  in  1  memory access done; read data valid in the same cycle
- SpeicherLeseDaten  in  DATA_WIDTH  memory read data
- Zeitueberschreitung  out  1  sticky timeout error flag

## Operation
- **States:** IDLE, BEFEHL (fetch read), LESEN (data read), SCHREIBEN (data write), ANTWORT (completion).
- **Arming:** each requester (fetch, load, store) has an `armed` flag.
  - The flag is set to 1 by reset.
  - It is cleared when that requester completes.
  - It is set again in any cycle where its request input is sampled low.
  - A requester is eligible only while its request is high and its flag is set. This makes the handshake four-phase: a request held high is never served twice.
- **IDLE, grant on edge:** priority is store > load > fetch among eligible requesters.
  - Store and load both high is illegal; store wins and the load stays pending.
  - On grant, the address and (for a store) `SchreibDaten` are registered into `SpeicherAdresse`/`SpeicherDaten`. The matching strobe is asserted and the watchdog counter is cleared.
- **BEFEHL/LESEN/SCHREIBEN:**
  - The strobe, address and data are held constant.
  - The counter increments every cycle.
  - When `SpeicherBereit` is sampled high: drop the strobe, go to ANTWORT, and capture `SpeicherLeseDaten` into `Befehl` (BEFEHL) or `LeseDaten` (LESEN).
- **Watchdog:** if TIMEOUT≠0 and the counter reaches TIMEOUT without `SpeicherBereit`:
  - drop the strobe;
  - set `Zeitueberschreitung`;
  - load all-ones into `Befehl`/`LeseDaten` (reads only);
  - go to ANTWORT.
- **ANTWORT:** exactly one cycle. The matching done pulse is high, the served requester's `armed` flag is cleared, and the next state is IDLE.
- **Request inputs during an access:** changes are ignored, including a request dropped mid-access; the access still completes.
- **Ignored conditions:** `SpeicherBereit` is ignored in IDLE and ANTWORT. `Zeitueberschreitung` is cleared only by Reset.
- **Counter width:** ceil(log2(TIMEOUT+1)), minimum 1 bit. The counter saturates and never wraps.
- **Output hold:** `Befehl` and `LeseDaten` change only on their own completion.

## Timing
- **Reset (asynchronous, immediate):**
  - state IDLE, all strobes and pulses 0;
  - `SpeicherAdresse`, `SpeicherDaten`, `Befehl`, `LeseDaten` 0;
  - `Zeitueberschreitung` 0, counter 0, all `armed` flags 1.
- **Reset mid-access:** the strobe drops without waiting for the clock, and no done pulse is issued.
- **Request accepted at edge 0:** the strobe is high from cycle 1.
- **`SpeicherBereit` sampled at edge n:** the done pulse is high in cycle n+1 and the read data is valid from cycle n+1.
- **Minimum latency:** 2 cycles from request sample to done pulse, with a 1-cycle strobe. The next grant is possible at the edge ending ANTWORT, i.e. the new strobe starts in cycle n+2.
- **Timeout:** the strobe is high for exactly TIMEOUT cycles. The pulse and `Zeitueberschreitung` rise together in the ANTWORT cycle.
- **No combinational paths:** no output depends combinationally on any input.

## Test plan
- **Zero-wait fetch:** `LoadBefehlSignal`=1, `BefehlAdresse`=0x40, memory returns 0x12345678 with `SpeicherBereit` in the first strobe cycle.
  - Required: `SpeicherLesen` high exactly 1 cycle at address 0x40.
  - Required: `BefehlGeladen` pulses 2 cycles after the request and `Befehl`=0x12345678.
- **Priority:** fetch and store requested in the same cycle (store 0xCAFEBABE at address 0x100).
  - Required: the write is served first and `DatenGespeichert` pulses.
  - Required: the fetch strobe starts in the cycle after ANTWORT, then `BefehlGeladen` pulses.
- **Re-arm:** a load request is held high for 10 cycles after `DatenGeladen`.
  - Required: no second access.
  - Required: after dropping the request for 1 cycle and raising it again, exactly one new read occurs.
- **Wait states:** `SpeicherBereit` is delayed 5 cycles.
  - Required: the strobe, address and data stay stable for 6 cycles, followed by one pulse and correct data.
- **Timeout:** TIMEOUT=4 and `SpeicherBereit` is never asserted.
  - Required: the strobe is high 4 cycles, `DatenGeladen` pulses, `LeseDaten`=0xFFFFFFFF, and `Zeitueberschreitung` is set and stays set until Reset.
- **Mid-access reset:** Reset is asserted during the 3rd wait cycle of a store.
  - Required: `SpeicherSchreiben` falls immediately, with no `DatenGespeichert` pulse.
  - Required: a fresh request after Reset is served normally.

Source files
------------

// File: rtl/speicher_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : speicher_arbiter
//  Purpose  : Shares the single memory port between instruction fetch and
//             data load/store. Grants one access at a time (store > load >
//             fetch). Holds the access until SpeicherBereit is seen. Returns
//             a one-cycle completion pulse to the control unit. A watchdog
//             aborts accesses that never complete.
//  Ports    : Clock, Reset                 - clock, async active-high reset
//             LoadBefehlSignal/BefehlAdresse -> Befehl, BefehlGeladen
//             LoadDatenSignal/StoreDatenSignal/DatenAdresse/SchreibDaten
//                                           -> LeseDaten, DatenGeladen,
//                                              DatenGespeichert
//             SpeicherAdresse/SpeicherDaten/SpeicherLesen/SpeicherSchreiben
//                                           -> memory request side
//             SpeicherBereit/SpeicherLeseDaten <- memory response side
//             Zeitueberschreitung           - sticky watchdog error flag
//  Revision : 1.0 - initial release
// ============================================================================
module speicher_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LoadBefehlSignal,
    input  logic [ADDR_WIDTH-1:0] BefehlAdresse,
    output logic [DATA_WIDTH-1:0] Befehl,
    output logic                  BefehlGeladen,
    input  logic                  LoadDatenSignal,
    input  logic                  StoreDatenSignal,
    input  logic [ADDR_WIDTH-1:0] DatenAdresse,
    input  logic [DATA_WIDTH-1:0] SchreibDaten,
    output logic [DATA_WIDTH-1:0] LeseDaten,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic [ADDR_WIDTH-1:0] SpeicherAdresse,
    output logic [DATA_WIDTH-1:0] SpeicherDaten,
    output logic                  SpeicherLesen,
    output logic                  SpeicherSchreiben,
    input  logic                  SpeicherBereit,
    input  logic [DATA_WIDTH-1:0] SpeicherLeseDaten,
    output logic                  Zeitueberschreitung
);

    localparam int CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    // Abort happens at the edge that closes the TIMEOUT-th strobe cycle,
    // i.e. when the counter still shows TIMEOUT-1.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT < 1) ? {CNT_WIDTH{1'b0}} : CNT_WIDTH'(TIMEOUT - 1);
    localparam bit WATCHDOG_ON = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BEFEHL    = 3'd1,
        LESEN     = 3'd2,
        SCHREIBEN = 3'd3,
        ANTWORT   = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nx;
    logic [ADDR_WIDTH-1:0] adr_nx;
    logic [DATA_WIDTH-1:0] wdat_nx;
    logic                  lesen_nx, schreiben_nx;
    logic [DATA_WIDTH-1:0] befehl_nx, lese_nx;
    logic                  bg_nx, dg_nx, ds_nx;
    logic                  zeit_nx;

    logic armed_fetch, armed_load, armed_store;
    logic armed_fetch_nx, armed_load_nx, armed_store_nx;
    logic elig_fetch, elig_load, elig_store;

    // A completion pulse is high only during ANTWORT, so it identifies the
    // requester just served; that requester is excluded from the grant made
    // at the edge closing ANTWORT, since its flag clears on that same edge.
    assign elig_store = StoreDatenSignal && armed_store && !DatenGespeichert;
    assign elig_load  = LoadDatenSignal  && armed_load  && !DatenGeladen;
    assign elig_fetch = LoadBefehlSignal && armed_fetch && !BefehlGeladen;

    // A low request re-arms; otherwise completion disarms.
    assign armed_store_nx = !StoreDatenSignal || (armed_store && !DatenGespeichert);
    assign armed_load_nx  = !LoadDatenSignal  || (armed_load  && !DatenGeladen);
    assign armed_fetch_nx = !LoadBefehlSignal || (armed_fetch && !BefehlGeladen);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            SpeicherAdresse     <= '0;
            SpeicherDaten       <= '0;
            SpeicherLesen       <= 1'b0;
            SpeicherSchreiben   <= 1'b0;
            Befehl              <= '0;
            LeseDaten           <= '0;
            BefehlGeladen       <= 1'b0;
            DatenGeladen        <= 1'b0;
            DatenGespeichert    <= 1'b0;
            Zeitueberschreitung <= 1'b0;
            armed_fetch         <= 1'b1;
            armed_load          <= 1'b1;
            armed_store         <= 1'b1;
        end else begin
            state               <= state_nx;
            cnt                 <= cnt_nx;
            SpeicherAdresse     <= adr_nx;
            SpeicherDaten       <= wdat_nx;
            SpeicherLesen       <= lesen_nx;
            SpeicherSchreiben   <= schreiben_nx;
            Befehl              <= befehl_nx;
            LeseDaten           <= lese_nx;
            BefehlGeladen       <= bg_nx;
            DatenGeladen        <= dg_nx;
            DatenGespeichert    <= ds_nx;
            Zeitueberschreitung <= zeit_nx;
            armed_fetch         <= armed_fetch_nx;
            armed_load          <= armed_load_nx;
            armed_store         <= armed_store_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        adr_nx       = SpeicherAdresse;
        wdat_nx      = SpeicherDaten;
        lesen_nx     = SpeicherLesen;
        schreiben_nx = SpeicherSchreiben;
        befehl_nx    = Befehl;
        lese_nx      = LeseDaten;
        bg_nx        = 1'b0;
        dg_nx        = 1'b0;
        ds_nx        = 1'b0;
        zeit_nx      = Zeitueberschreitung;

        case (state)
            IDLE, ANTWORT: begin
                state_nx = IDLE;
                if (elig_store) begin
                    state_nx     = SCHREIBEN;
                    adr_nx       = DatenAdresse;
                    wdat_nx      = SchreibDaten;
                    schreiben_nx = 1'b1;
                    cnt_nx       = '0;
                end else if (elig_load) begin
                    state_nx = LESEN;
                    adr_nx   = DatenAdresse;
                    lesen_nx = 1'b1;
                    cnt_nx   = '0;
                end else if (elig_fetch) begin
                    state_nx = BEFEHL;
                    adr_nx   = BefehlAdresse;
                    lesen_nx = 1'b1;
                    cnt_nx   = '0;
                end
            end

            BEFEHL, LESEN, SCHREIBEN: begin
                if (SpeicherBereit || (WATCHDOG_ON && (cnt == CNT_LAST))) begin
                    state_nx     = ANTWORT;
                    lesen_nx     = 1'b0;
                    schreiben_nx = 1'b0;
                    // A real response wins over a watchdog abort in the
                    // same cycle; an abort returns all-ones on reads.
                    if (!SpeicherBereit) begin
                        zeit_nx = 1'b1;
                    end
                    case (state)
                        BEFEHL: begin
                            bg_nx     = 1'b1;
                            befehl_nx = SpeicherBereit ? SpeicherLeseDaten : '1;
                        end
                        LESEN: begin
                            dg_nx   = 1'b1;
                            lese_nx = SpeicherBereit ? SpeicherLeseDaten : '1;
                        end
                        default: begin
                            ds_nx = 1'b1;
                        end
                    endcase
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
